key_expansion_block: RTL and testbench
======================================

KEY_EXPANSION_BLOCK -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have parameter NK, default 6, meaning key length in 32-bit words; legal values 4, 6, 8.
REQ-002 SHALL have parameter NR, default 12, meaning number of rounds; NR = NK + 6.
REQ-003 SHALL have parameter NB, default 4, meaning state columns; only 4 is legal.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, one-cycle request to expand key_in.
REQ-008 SHALL have port key_in, input, 32*NK bits, cipher key; byte 0 in the MSBs.
REQ-009 SHALL have port busy, output, 1 bit, expansion in progress.
REQ-010 SHALL have port key_valid, output, 1 bit, exp_key is complete and stable.
REQ-011 SHALL have port exp_key, output, 128*(NR+1) bits, all round keys; round key r at bits [128*(NR+1-r)-1 -: 128], so round 0 is in the MSBs and round NR is at [127:0].

Function
REQ-012 SHALL follow the FIPS-197 schedule: words w[0..NK-1] = key_in words, MSB word first; w[i] = w[i-NK] XOR temp for i = NK..4*(NR+1)-1.
REQ-013 SHALL form temp as follows: if i mod NK = 0, temp = SubWord(RotWord(w[i-1])) XOR Rcon[i/NK]; otherwise temp = w[i-1], except as extended by REQ-023.
REQ-014 SHALL use Rcon[j] first bytes 01,02,04,08,10,20,40,80,1b,36 for j = 1..10, with the lower three bytes zero.
REQ-015 SHALL implement SubWord with the standard AES forward S-box applied to each byte; RotWord is a left rotate by one byte.
REQ-016 SHALL, when start is sampled high while not busy, load w[0..NK-1] in that cycle, set busy=1 and key_valid=0.
REQ-017 SHALL generate exactly one word per subsequent cycle; busy stays high for 4*(NR+1)-NK cycles after the start cycle (NK=6: 46 cycles).
REQ-018 SHALL, in the cycle after the last word is written, set busy=0 and key_valid=1; key_valid then holds until the next accepted start or reset.
REQ-019 SHALL ignore start while busy=1; the expansion in progress completes unaffected.
REQ-020 SHALL, when start is asserted in the same cycle that key_valid is 1, accept it: key_valid falls and a new expansion begins.
REQ-021 SHALL sample key_in only in the start cycle; later key_in changes have no effect.
REQ-022 SHALL allow exp_key bits to change only while busy=1; exp_key is undefined for use while key_valid=0.

Configuration
REQ-023 SHALL, with macro KEY_EXPANSION_NK8_EN defined, also apply temp = SubWord(w[i-1]) when NK > 6 and i mod NK = 4 (AES-256 support).
REQ-024 SHALL, without KEY_EXPANSION_NK8_EN, omit that logic and treat NK = 8 as illegal, with an elaboration-time error or $error.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously force busy=0, key_valid=0, exp_key=0 and the word counter to 0.
REQ-026 SHALL, when reset is asserted mid-expansion, abort the expansion; after release, the block stays idle until a new start.

Verification
REQ-027 SHALL pass: NK=6, key 000102030405060708090a0b0c0d0e0f1011121314151617, start pulse -> 46 cycles later key_valid=1, exp_key[127:0]=a4970a331a78dc09c418c271e3a41d5d, round 0 = 000102030405060708090a0b0c0d0e0f.
REQ-028 SHALL pass: NK=4, key 000102030405060708090a0b0c0d0e0f -> round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, round 10 = 13111d7fe3944a17f307a78b4d2b30c5, key_valid after 40 cycles.
REQ-029 SHALL pass: NK=4, key 2b7e151628aed2a6abf7158809cf4f3c -> round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 SHALL pass: NK=8 with KEY_EXPANSION_NK8_EN, key 00..1f -> exp_key[127:0]=24fc79ccbf0979e9371ac23c6d68de36.
REQ-031 SHALL pass: second start pulsed while busy -> ignored, result equals the first key's expansion; rst_n low at cycle 10 -> all outputs 0 immediately, and no key_valid appears until a new start is given.

Source files
------------

// File: rtl/key_expansion_block.sv
// AES key schedule: one round-key word per cycle into a shift register that ends up holding all round keys.
// Optional macro KEY_EXPANSION_NK8_EN adds the AES-256 SubWord step and allows NK = 8.
//
//   state  | meaning
//   S_IDLE | no key loaded since reset, waiting for start
//   S_RUN  | generating words NK .. 4*(NR+1)-1, one per cycle
//   S_DONE | exp_key complete and stable, start accepted again
module key_expansion_block #(
    parameter int NK = 6,
    parameter int NR = 12,
    parameter int NB = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*NK-1:0]      key_in,
    output logic                  busy,
    output logic                  key_valid,
    output logic [128*(NR+1)-1:0] exp_key
);

    localparam int TOTAL = 4 * (NR + 1);
    localparam int EXPW  = 32 * TOTAL;
    localparam int KW    = 32 * NK;
    localparam int CW    = $clog2(TOTAL);

    generate
`ifdef KEY_EXPANSION_NK8_EN
        if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
            $error("key_expansion_block: NK must be 4, 6 or 8");
        end
`else
        if (!(NK == 4 || NK == 6)) begin : g_bad_nk
            $error("key_expansion_block: NK must be 4 or 6 (NK = 8 needs KEY_EXPANSION_NK8_EN)");
        end
`endif
        if (NR != NK + 6) begin : g_bad_nr
            $error("key_expansion_block: NR must equal NK + 6");
        end
        if (NB != 4) begin : g_bad_nb
            $error("key_expansion_block: NB must be 4");
        end
    endgenerate

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      pos_q, pos_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [EXPW-1:0] exp_q, exp_d;

    logic [31:0] w_prev, sub_in, sub_out, temp, w_new;

    // exp_q is a word shift register: w[i-1] sits in the low word, w[i-NK] NK words up
    always_comb begin
        w_prev  = exp_q[31:0];
        sub_in  = {w_prev[23:0], w_prev[31:24]};
        temp    = w_prev;
`ifdef KEY_EXPANSION_NK8_EN
        if (NK > 6 && pos_q == 3'd4) begin
            sub_in = w_prev;
        end
`endif
        sub_out = sub_word(sub_in);
`ifdef KEY_EXPANSION_NK8_EN
        if (pos_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK > 6 && pos_q == 3'd4) begin
            temp = sub_out;
        end
`else
        if (pos_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end
`endif
        w_new = exp_q[KW-1 -: 32] ^ temp;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        rcon_d  = rcon_q;
        exp_d   = exp_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    exp_d   = {exp_q[EXPW-KW-1:0], key_in};
                    cnt_d   = CW'(NK);
                    pos_d   = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                exp_d = {exp_q[EXPW-33:0], w_new};
                cnt_d = cnt_q + CW'(1);
                pos_d = (pos_q == 3'(NK - 1)) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (cnt_q == CW'(TOTAL - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            rcon_q  <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            exp_q   <= exp_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign key_valid = (state_q == S_DONE);
    assign exp_key   = exp_q;

endmodule

// File: tb/tb_key_expansion_block.sv
// Bench for key_expansion_block: NK=6 and NK=4 instances (plus NK=8 when KEY_EXPANSION_NK8_EN is defined),
// checked against known-answer vectors and a key-schedule model whose S-box is derived from GF(2^8).
module tb_key_expansion_block;

    logic clk, rst_n;

    logic          st6, busy6, kv6;
    logic [191:0]  key6;
    logic [1663:0] ex6;

    logic          st4, busy4, kv4;
    logic [127:0]  key4;
    logic [1407:0] ex4;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1663:0] sb6_q[$];
    logic [1407:0] sb4_q[$];
    logic [7:0]    sb_t [0:255];

    key_expansion_block #(.NK(6), .NR(12), .NB(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(st6), .key_in(key6),
        .busy(busy6), .key_valid(kv6), .exp_key(ex6)
    );

    key_expansion_block #(.NK(4), .NR(10), .NB(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .key_in(key4),
        .busy(busy4), .key_valid(kv4), .exp_key(ex4)
    );

`ifdef KEY_EXPANSION_NK8_EN
    logic          st8, busy8, kv8;
    logic [255:0]  key8;
    logic [1919:0] ex8;

    key_expansion_block #(.NK(8), .NR(14), .NB(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .key_in(key8),
        .busy(busy8), .key_valid(kv8), .exp_key(ex8)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
    endfunction

    // Returns w[0..total-1] MSB-first, right-aligned in 1920 bits; key is right-aligned in 256 bits.
    function automatic logic [1919:0] model_expand(input int nk, input logic [255:0] key);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int            total;
        total = 4 * (nk + 7);
        r = '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = xt(rc);
                t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = sw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < total; i++) r[32*(total-i)-1 -: 32] = w[i];
        return r;
    endfunction

    task automatic start6(input logic [191:0] k, input bit push);
        logic [1919:0] m;
        @(negedge clk);
        st6 = 1'b1; key6 = k;
        if (push) begin
            m = model_expand(6, {64'h0, k});
            sb6_q.push_back(m[1663:0]);
        end
        @(negedge clk);
        st6 = 1'b0;
    endtask

    task automatic start4(input logic [127:0] k);
        logic [1919:0] m;
        @(negedge clk);
        st4 = 1'b1; key4 = k;
        m = model_expand(4, {128'h0, k});
        sb4_q.push_back(m[1407:0]);
        @(negedge clk);
        st4 = 1'b0;
    endtask

    task automatic wait6(output int n);
        n = 0;
        while (kv6 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (kv4 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL reset_busy6: got %b want 0", busy6); end
        n_cmp++; if (kv6 !== 1'b0) begin n_bad++; $display("FAIL reset_kv6: got %b want 0", kv6); end
        n_cmp++; if (ex6 !== '0) begin n_bad++; $display("FAIL reset_exp6: low round got %h want 0", ex6[127:0]); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy4: got %b want 0", busy4); end
        n_cmp++; if (kv4 !== 1'b0) begin n_bad++; $display("FAIL reset_kv4: got %b want 0", kv4); end
        n_cmp++; if (ex4 !== '0) begin n_bad++; $display("FAIL reset_exp4: low round got %h want 0", ex4[127:0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy6 !== 1'b0 || kv6 !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0/0", busy6, kv6);
        end
    endtask

    task automatic test_kat6();
        int n;
        logic [1663:0] e;
        start6(192'h000102030405060708090a0b0c0d0e0f1011121314151617, 1'b1);
        n_cmp++; if (busy6 !== 1'b1) begin n_bad++; $display("FAIL kat6_busy: got %b want 1", busy6); end
        wait6(n);
        n_cmp++; if (n !== 46) begin n_bad++; $display("FAIL kat6_latency: got %0d cycles want 46", n); end
        n_cmp++; if (busy6 !== 1'b0) begin n_bad++; $display("FAIL kat6_busy_done: got %b want 0", busy6); end
        n_cmp++; if (ex6[127:0] !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
            n_bad++; $display("FAIL kat6_round12: got %h want a4970a331a78dc09c418c271e3a41d5d", ex6[127:0]);
        end
        n_cmp++; if (ex6[1663 -: 128] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_bad++; $display("FAIL kat6_round0: got %h want 000102030405060708090a0b0c0d0e0f", ex6[1663 -: 128]);
        end
        n_cmp++;
        if (sb6_q.size() == 0) begin n_bad++; $display("FAIL kat6_sb: scoreboard empty, want 1 entry"); end
        else begin
            e = sb6_q.pop_front();
            if (ex6 !== e) begin
                n_bad++; $display("FAIL kat6_sb: r0 got %h want %h, r12 got %h want %h",
                                  ex6[1663 -: 128], e[1663 -: 128], ex6[127:0], e[127:0]);
            end
        end
    endtask

    task automatic test_kat4();
        int n;
        logic [1407:0] e;
        start4(128'h000102030405060708090a0b0c0d0e0f);
        wait4(n);
        n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL kat4_latency: got %0d cycles want 40", n); end
        n_cmp++; if (ex4[1279 -: 128] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
            n_bad++; $display("FAIL kat4_round1: got %h want d6aa74fdd2af72fadaa678f1d6ab76fe", ex4[1279 -: 128]);
        end
        n_cmp++; if (ex4[127:0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_bad++; $display("FAIL kat4_round10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", ex4[127:0]);
        end
        n_cmp++;
        if (sb4_q.size() == 0) begin n_bad++; $display("FAIL kat4_sb: scoreboard empty, want 1 entry"); end
        else begin
            e = sb4_q.pop_front();
            if (ex4 !== e) begin
                n_bad++; $display("FAIL kat4_sb: r0 got %h want %h, r10 got %h want %h",
                                  ex4[1407 -: 128], e[1407 -: 128], ex4[127:0], e[127:0]);
            end
        end
        // accepted directly from key_valid=1
        start4(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait4(n);
        n_cmp++; if (ex4[127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_bad++; $display("FAIL fips_round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", ex4[127:0]);
        end
        n_cmp++;
        if (sb4_q.size() == 0) begin n_bad++; $display("FAIL fips_sb: scoreboard empty, want 1 entry"); end
        else begin
            e = sb4_q.pop_front();
            if (ex4 !== e) begin
                n_bad++; $display("FAIL fips_sb: r0 got %h want %h, r10 got %h want %h",
                                  ex4[1407 -: 128], e[1407 -: 128], ex4[127:0], e[127:0]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic [1663:0] e6;
        logic [1407:0] e4;
        for (int t = 0; t < 3; t++) begin
            start6({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
            wait6(n);
            n_cmp++;
            if (sb6_q.size() == 0 || n >= 200) begin
                n_bad++; $display("FAIL rand6_%0d: no result after %0d cycles", t, n);
                if (sb6_q.size() != 0) e6 = sb6_q.pop_front();
            end else begin
                e6 = sb6_q.pop_front();
                if (ex6 !== e6) begin
                    n_bad++; $display("FAIL rand6_%0d: r0 got %h want %h, r12 got %h want %h", t,
                                      ex6[1663 -: 128], e6[1663 -: 128], ex6[127:0], e6[127:0]);
                end
            end
            start4({$urandom(), $urandom(), $urandom(), $urandom()});
            wait4(n);
            n_cmp++;
            if (sb4_q.size() == 0 || n >= 200) begin
                n_bad++; $display("FAIL rand4_%0d: no result after %0d cycles", t, n);
                if (sb4_q.size() != 0) e4 = sb4_q.pop_front();
            end else begin
                e4 = sb4_q.pop_front();
                if (ex4 !== e4) begin
                    n_bad++; $display("FAIL rand4_%0d: r0 got %h want %h, r10 got %h want %h", t,
                                      ex4[1407 -: 128], e4[1407 -: 128], ex4[127:0], e4[127:0]);
                end
            end
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        logic [1663:0] e;
        logic [1919:0] m;
        logic [191:0]  ka;
        ka = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        start6(ka, 1'b1);
        repeat (5) @(negedge clk);
        st6 = 1'b1; key6 = ~ka;
        @(negedge clk);
        st6 = 1'b0; key6 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        n_cmp++; if (busy6 !== 1'b1 || kv6 !== 1'b0) begin
            n_bad++; $display("FAIL ignore_busy_flags: busy=%b valid=%b want 1/0", busy6, kv6);
        end
        wait6(n);
        n_cmp++; if (n + 6 !== 46) begin n_bad++; $display("FAIL ignore_busy_latency: got %0d want 46", n + 6); end
        n_cmp++;
        if (sb6_q.size() == 0) begin n_bad++; $display("FAIL ignore_busy_sb: scoreboard empty, want 1 entry"); end
        else begin
            e = sb6_q.pop_front();
            if (ex6 !== e) begin
                n_bad++; $display("FAIL ignore_busy_sb: r0 got %h want %h, r12 got %h want %h",
                                  ex6[1663 -: 128], e[1663 -: 128], ex6[127:0], e[127:0]);
            end
        end
        // result holds while key_in wanders and no start is given
        repeat (4) begin
            @(negedge clk);
            key6 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        end
        m = model_expand(6, {64'h0, ka});
        n_cmp++; if (kv6 !== 1'b1 || ex6 !== m[1663:0]) begin
            n_bad++; $display("FAIL hold_valid: valid=%b want 1, r12 got %h want %h", kv6, ex6[127:0], m[127:0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [1663:0] e;
        start6({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
        n_cmp++; if (kv6 !== 1'b0 || busy6 !== 1'b1) begin
            n_bad++; $display("FAIL b2b_accept: valid=%b busy=%b want 0/1", kv6, busy6);
        end
        wait6(n);
        n_cmp++; if (n !== 46) begin n_bad++; $display("FAIL b2b_latency: got %0d want 46", n); end
        n_cmp++;
        if (sb6_q.size() == 0) begin n_bad++; $display("FAIL b2b_sb: scoreboard empty, want 1 entry"); end
        else begin
            e = sb6_q.pop_front();
            if (ex6 !== e) begin
                n_bad++; $display("FAIL b2b_sb: r0 got %h want %h, r12 got %h want %h",
                                  ex6[1663 -: 128], e[1663 -: 128], ex6[127:0], e[127:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, kv_seen, busy_seen;
        logic [1663:0] e;
        start6({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy6 !== 1'b0 || kv6 !== 1'b0 || ex6 !== '0) begin
            n_bad++; $display("FAIL reset_mid_async: busy=%b valid=%b r12=%h want 0/0/0", busy6, kv6, ex6[127:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        kv_seen = 0; busy_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (kv6 !== 1'b0) kv_seen++;
            if (busy6 !== 1'b0) busy_seen++;
        end
        n_cmp++; if (kv_seen !== 0 || busy_seen !== 0) begin
            n_bad++; $display("FAIL reset_mid_idle: valid cycles=%0d busy cycles=%0d want 0/0", kv_seen, busy_seen);
        end
        start6(192'h000102030405060708090a0b0c0d0e0f1011121314151617, 1'b1);
        wait6(n);
        n_cmp++;
        if (sb6_q.size() == 0 || n >= 200) begin
            n_bad++; $display("FAIL reset_mid_restart: no result after %0d cycles", n);
            if (sb6_q.size() != 0) e = sb6_q.pop_front();
        end else begin
            e = sb6_q.pop_front();
            if (ex6 !== e) begin
                n_bad++; $display("FAIL reset_mid_restart: r12 got %h want %h", ex6[127:0], e[127:0]);
            end
        end
    endtask

`ifdef KEY_EXPANSION_NK8_EN
    task automatic test_nk8();
        int n;
        logic [1919:0] m;
        @(negedge clk);
        st8 = 1'b1;
        key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        m = model_expand(8, key8);
        @(negedge clk);
        st8 = 1'b0;
        n = 0;
        while (kv8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 52) begin n_bad++; $display("FAIL nk8_latency: got %0d want 52", n); end
        n_cmp++; if (ex8[127:0] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            n_bad++; $display("FAIL nk8_round14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", ex8[127:0]);
        end
        n_cmp++; if (ex8 !== m) begin
            n_bad++; $display("FAIL nk8_model: r1 got %h want %h", ex8[1791 -: 128], m[1791 -: 128]);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        st6 = 1'b0; key6 = '0;
        st4 = 1'b0; key4 = '0;
`ifdef KEY_EXPANSION_NK8_EN
        st8 = 1'b0; key8 = '0;
`endif
        build_sbox();
        test_reset();
        test_kat6();
        test_kat4();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef KEY_EXPANSION_NK8_EN
        test_nk8();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
